// File: rtl/mem_ctrl.sv
// Word-organised RAM responder: word/halfword/byte loads and stores with range and alignment checks.
// Latency: valid access completes LATENCY cycles after acceptance, ready pulses the cycle after; errors answer one cycle after acceptance.
// Backpressure: no handshake; req is sampled only in IDLE and ignored while BUSY or DONE.
module mem_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        addr_err
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;

    // Request fields captured at acceptance; only the in-range address bits are kept.
    logic               lat_we;
    logic [1:0]         lat_size;
    logic [ADDR_W+1:0]  lat_addr;
    logic [31:0]        lat_wdata;

    logic [31:0]        mem [DEPTH];

    logic               req_err;
    logic [ADDR_W-1:0]  widx;
    logic [31:0]        cur_word;
    logic [31:0]        load_val;
    logic [31:0]        wdata_rep;
    logic [3:0]         byte_en;
    logic [31:0]        store_word;
    logic               access_fire;

    assign widx        = lat_addr[ADDR_W+1:2];
    assign cur_word    = mem[widx];
    assign access_fire = (state == BUSY) && (cnt == '0);

    // Classify the live request: illegal size, misalignment, or address beyond the RAM.
    always_comb begin
        req_err = 1'b0;
        if (size == 2'b11)
            req_err = 1'b1;
        if ((size == SZ_WORD) && (addr[1:0] != 2'b00))
            req_err = 1'b1;
        if ((size == SZ_HALF) && addr[0])
            req_err = 1'b1;
        if (addr[31:ADDR_W+2] != '0)
            req_err = 1'b1;
    end

    // Extract the addressed lane of the current word, zero-extended.
    always_comb begin
        load_val = '0;
        case (lat_size)
            SZ_WORD: load_val = cur_word;
            SZ_HALF: load_val = {16'h0000, lat_addr[1] ? cur_word[31:16] : cur_word[15:0]};
            SZ_BYTE: begin
                case (lat_addr[1:0])
                    2'd0:    load_val = {24'h0, cur_word[7:0]};
                    2'd1:    load_val = {24'h0, cur_word[15:8]};
                    2'd2:    load_val = {24'h0, cur_word[23:16]};
                    default: load_val = {24'h0, cur_word[31:24]};
                endcase
            end
            default: load_val = '0;
        endcase
    end

    // Build byte enables and replicated store data so every lane sees its source bytes.
    always_comb begin
        byte_en   = 4'b0000;
        wdata_rep = lat_wdata;
        case (lat_size)
            SZ_WORD: begin
                byte_en   = 4'b1111;
                wdata_rep = lat_wdata;
            end
            SZ_HALF: begin
                byte_en   = lat_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{lat_wdata[15:0]}};
            end
            SZ_BYTE: begin
                byte_en   = 4'b0001 << lat_addr[1:0];
                wdata_rep = {4{lat_wdata[7:0]}};
            end
            default: begin
                byte_en   = 4'b0000;
                wdata_rep = lat_wdata;
            end
        endcase
    end

    // Read-modify-write merge: unaddressed bytes keep the stored value.
    always_comb begin
        store_word = cur_word;
        for (int b = 0; b < 4; b++) begin
            if (byte_en[b])
                store_word[8*b +: 8] = wdata_rep[8*b +: 8];
        end
    end

    // RAM write happens only on the last BUSY edge, so an aborted access never writes.
    always_ff @(posedge clk) begin
        if (access_fire && lat_we)
            mem[widx] <= store_word;
    end

    // Control FSM with registered outputs and the latency counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            ready     <= 1'b0;
            busy      <= 1'b0;
            addr_err  <= 1'b0;
            rdata     <= '0;
            lat_we    <= 1'b0;
            lat_size  <= SZ_WORD;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ready    <= 1'b0;
                    addr_err <= 1'b0;
                    if (req) begin
                        lat_we    <= we;
                        lat_size  <= size;
                        lat_addr  <= addr[ADDR_W+1:0];
                        lat_wdata <= wdata;
                        if (req_err) begin
                            state    <= DONE;
                            ready    <= 1'b1;
                            addr_err <= 1'b1;
                        end else begin
                            state <= BUSY;
                            busy  <= 1'b1;
                            cnt   <= CNT_W'(LATENCY - 1);
                        end
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        ready <= 1'b1;
                        if (!lat_we)
                            rdata <= load_val;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    ready    <= 1'b0;
                    addr_err <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomised bench for mem_ctrl against a byte-array reference model with per-cycle output checking.
// Latency: expected ready/busy windows are derived from acceptance cycle and LATENCY.
// Backpressure: driver waits for each completion before issuing the next request.
module tb_mem_ctrl;

    localparam int ADDR_W  = 8;
    localparam int LATENCY = 2;
    localparam int NBYTES  = 4 << ADDR_W;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        addr_err;

    mem_ctrl #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .we       (we),
        .size     (size),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready),
        .busy     (busy),
        .addr_err (addr_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: byte-addressed RAM and the last successful load value.
    logic [7:0]  mb [NBYTES];
    logic [31:0] model_rdata = '0;

    // Outstanding transaction as seen by the per-cycle comparator.
    bit          active = 1'b0;
    bit          cmp_en = 1'b0;
    bit          t_err;
    bit          t_we;
    int          t_e0;
    int          t_rcyc;
    logic [31:0] t_val;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic bit err_of(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b11) return 1'b1;
        if (sz == 2'b00 && (a % 4) != 0) return 1'b1;
        if (sz == 2'b01 && (a % 2) != 0) return 1'b1;
        if ((a >> (ADDR_W + 2)) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int nbytes_of(input logic [1:0] sz);
        return (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : 1;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic [31:0] a);
        logic [31:0] v = '0;
        for (int i = 0; i < nbytes_of(sz); i++)
            v = v | (32'(mb[int'(a) + i]) << (8 * i));
        return v;
    endfunction

    task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        for (int i = 0; i < nbytes_of(sz); i++)
            mb[int'(a) + i] = 8'(d >> (8 * i));
    endtask

    // Every cycle: compare all outputs against what the outstanding transaction implies.
    always @(negedge clk) begin
        if (cmp_en) begin
            logic        e_rdy, e_busy, e_err;
            logic [31:0] e_rd;
            if (reset) begin
                e_rdy = 0; e_busy = 0; e_err = 0; e_rd = '0;
            end else begin
                e_rdy  = active && (cyc == t_rcyc);
                e_busy = active && !t_err && (cyc >= t_e0) && (cyc < t_rcyc);
                e_err  = e_rdy && t_err;
                e_rd   = (active && !t_err && !t_we && cyc >= t_rcyc) ? t_val : model_rdata;
            end
            check("cyc_ready", 32'(ready), 32'(e_rdy));
            check("cyc_busy", 32'(busy), 32'(e_busy));
            check("cyc_addr_err", 32'(addr_err), 32'(e_err));
            check("cyc_rdata", rdata, e_rd);
        end
    end

    // Issue one access and wait for its completion; optional noise on inputs while in flight.
    task automatic access(input logic w, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] d, input bit noise);
        int  k;
        bit  seen = 0;
        @(posedge clk); #2;
        t_err  = err_of(sz, a);
        t_we   = w;
        k      = cyc;
        t_e0   = k + 1;
        t_rcyc = t_err ? t_e0 : t_e0 + LATENCY;
        t_val  = (!w && !t_err) ? model_load(sz, a) : model_rdata;
        active = 1'b1;
        req = 1'b1; we = w; size = sz; addr = a; wdata = d;
        for (int n = 0; n < 30 && !seen; n++) begin
            @(posedge clk); #2;
            if (ready) begin
                seen = 1;
                check("latency", 32'(cyc - k), 32'(t_err ? 1 : LATENCY + 1));
                check("ready_err", 32'(addr_err), 32'(t_err));
            end
            if (noise) begin
                req = seen ? 1'b1 : ~req;
                we = 1'($urandom); size = 2'($urandom); addr = $urandom; wdata = $urandom;
            end else begin
                req = 1'b0;
                we = 1'($urandom); size = 2'($urandom); addr = $urandom; wdata = $urandom;
            end
        end
        if (!seen) check("ready_timeout", 32'(0), 32'(1));
        @(posedge clk); #2;
        req = 1'b0;
        if (!t_err) begin
            if (w) model_store(sz, a, d);
            else   model_rdata = t_val;
        end
        active = 1'b0;
    endtask

    task automatic expect_rd(input string name, input logic [31:0] lit);
        check({name, "_dut"}, rdata, lit);
        check({name, "_model"}, model_rdata, lit);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;

        // Reset state.
        #3;
        check("rst_ready", 32'(ready), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_addr_err", 32'(addr_err), 32'(0));
        check("rst_rdata", rdata, 32'h0);
        @(posedge clk); @(posedge clk); #2;
        reset  = 1'b0;
        cmp_en = 1'b1;

        // Fill RAM so every later load has a defined value.
        for (int w = 0; w < (1 << ADDR_W); w++)
            access(1'b1, 2'b00, 32'(w * 4), $urandom, 1'b0);

        // Word store then load.
        access(1'b1, 2'b00, 32'h10, 32'hDEADBEEF, 1'b0);
        access(1'b0, 2'b00, 32'h10, 32'h0, 1'b0);
        expect_rd("word_load", 32'hDEADBEEF);

        // Byte store, word and byte loads.
        access(1'b1, 2'b10, 32'h11, 32'hFFFF_FFAA, 1'b0);
        access(1'b0, 2'b00, 32'h10, 32'h0, 1'b0);
        expect_rd("byte_store_word", 32'hDEADAAEF);
        access(1'b0, 2'b10, 32'h13, 32'h0, 1'b0);
        expect_rd("byte_load", 32'h000000DE);

        // Halfword load and store.
        access(1'b0, 2'b01, 32'h12, 32'h0, 1'b0);
        expect_rd("half_load", 32'h0000DEAD);
        access(1'b1, 2'b01, 32'h10, 32'h5555_1234, 1'b0);
        access(1'b0, 2'b00, 32'h10, 32'h0, 1'b0);
        expect_rd("half_store_word", 32'hDEAD1234);

        // Misaligned, illegal size, out-of-range.
        access(1'b0, 2'b00, 32'h13, 32'h0, 1'b0);
        access(1'b1, 2'b01, 32'h11, 32'hBBBB, 1'b0);
        access(1'b0, 2'b11, 32'h20, 32'h0, 1'b0);
        access(1'b0, 2'b00, 32'h400, 32'h0, 1'b0);
        expect_rd("err_rdata_kept", 32'hDEAD1234);
        access(1'b0, 2'b00, 32'h10, 32'h0, 1'b0);
        expect_rd("err_ram_kept", 32'hDEAD1234);

        // Reset during BUSY aborts the store.
        @(posedge clk); #2;
        req = 1'b1; we = 1'b1; size = 2'b00; addr = 32'h10; wdata = 32'h0;
        t_err = 0; t_we = 1; t_e0 = cyc + 1; t_rcyc = t_e0 + LATENCY; t_val = model_rdata;
        active = 1'b1;
        @(posedge clk); #2;
        req = 1'b0;
        check("mid_busy", 32'(busy), 32'(1));
        #1;
        reset = 1'b1;
        active = 1'b0;
        model_rdata = '0;
        #1;
        check("abort_ready", 32'(ready), 32'(0));
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_addr_err", 32'(addr_err), 32'(0));
        check("abort_rdata", rdata, 32'h0);
        @(posedge clk); #2;
        reset = 1'b0;
        access(1'b0, 2'b00, 32'h10, 32'h0, 1'b0);
        expect_rd("abort_ram_kept", 32'hDEAD1234);

        // req toggling during BUSY and DONE is ignored.
        access(1'b1, 2'b00, 32'h10, 32'hCAFEF00D, 1'b1);
        access(1'b0, 2'b00, 32'h10, 32'h0, 1'b1);
        expect_rd("noise_word", 32'hCAFEF00D);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            sz = 2'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, NBYTES - 1));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b00) a[1:0] = 2'b00;
                if (sz == 2'b01) a[0]   = 1'b0;
            end
            if ($urandom_range(0, 9) == 0)
                a = $urandom | 32'h0000_0400;
            access(1'($urandom), sz, a, $urandom, $urandom_range(0, 3) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
